// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle for the memory responder: AW, W, B, AR and R channels.
interface axi_mem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a word-addressed RAM. INCR bursts only, one
// outstanding transaction per direction, read and write fully independent.
module axi_mem_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic               s00_axi_aclk,
  input  logic               s00_axi_aresetn,
  axi_mem_responder_if.slave s00_axi
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Response codes are ordered so that the numerically larger one is worse.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Word index is kept full width so beats past the top never alias to word 0.
  function automatic logic in_range(input logic below, input logic [ADDR_WIDTH-1:0] idx);
    return !below && (idx[ADDR_WIDTH-1:IDX_W] == '0);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  rdy_q, rdy_d;
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic                  w_below_q, w_below_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_bad_q, w_bad_d;
  logic [1:0]            w_err_q, w_err_d;
  logic                  mem_we;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic                  r_below_q, r_below_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_bad_q, r_bad_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rlast_q, rlast_d;
  logic                  r_load;
  logic                  r_ok;

  logic [ADDR_WIDTH-1:0] aw_off, ar_off;
  assign aw_off = s00_axi.awaddr - BASE_ADDR;
  assign ar_off = s00_axi.araddr - BASE_ADDR;

  // Sideband attributes are accepted but carry no meaning for this memory.
  logic unused_ok;
  assign unused_ok = ^{s00_axi.awlock, s00_axi.awcache, s00_axi.awprot, s00_axi.awqos,
                       s00_axi.arlock, s00_axi.arcache, s00_axi.arprot, s00_axi.arqos};

  assign rdy_d             = 1'b1;
  assign s00_axi.awready   = rdy_q && (w_state_q == W_IDLE);
  assign s00_axi.wready    = (w_state_q == W_DATA);
  assign s00_axi.bvalid    = (w_state_q == W_RESP);
  assign s00_axi.bresp     = w_err_q;
  assign s00_axi.arready   = rdy_q && (r_state_q == R_IDLE);
  assign s00_axi.rvalid    = (r_state_q == R_DATA);
  assign s00_axi.rdata     = rdata_q;
  assign s00_axi.rresp     = rresp_q;
  assign s00_axi.rlast     = rlast_q;

  // Write channel: latch burst on AW, count beats, accumulate the worst response.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_below_d = w_below_q;
    w_cnt_d   = w_cnt_q;
    w_bad_d   = w_bad_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (s00_axi.awvalid && s00_axi.awready) begin
        w_idx_d   = aw_off >> ADDR_LSB;
        w_below_d = (s00_axi.awaddr < BASE_ADDR);
        w_cnt_d   = s00_axi.awlen;
        w_bad_d   = (s00_axi.awburst != BURST_INCR) || (s00_axi.awsize != 3'(ADDR_LSB));
        w_err_d   = w_bad_d ? RESP_SLVERR : RESP_OKAY;
        w_state_d = W_DATA;
      end
      W_DATA: if (s00_axi.wvalid) begin
        if (s00_axi.wlast != (w_cnt_q == 8'd0)) w_err_d = worst(w_err_d, RESP_SLVERR);
        if (!in_range(w_below_q, w_idx_q))      w_err_d = worst(w_err_d, RESP_DECERR);
        else if (!w_bad_q)                      mem_we  = 1'b1;
        w_idx_d = w_idx_q + ADDR_WIDTH'(1);
        w_cnt_d = w_cnt_q - 8'd1;
        if (w_cnt_q == 8'd0) w_state_d = W_RESP;
      end
      W_RESP: if (s00_axi.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: a beat is fetched into the output register on AR and on each
  // accepted beat, so outputs hold while stalled and stream one beat per cycle.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_below_d = r_below_q;
    r_cnt_d   = r_cnt_q;
    r_bad_d   = r_bad_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: if (s00_axi.arvalid && s00_axi.arready) begin
        r_idx_d   = ar_off >> ADDR_LSB;
        r_below_d = (s00_axi.araddr < BASE_ADDR);
        r_cnt_d   = s00_axi.arlen;
        r_bad_d   = (s00_axi.arburst != BURST_INCR) || (s00_axi.arsize != 3'(ADDR_LSB));
        r_load    = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (s00_axi.rready) begin
        if (r_cnt_q == 8'd0) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          r_idx_d = r_idx_q + ADDR_WIDTH'(1);
          r_cnt_d = r_cnt_q - 8'd1;
          r_load  = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    r_ok = in_range(r_below_d, r_idx_d);
    if (r_load) begin
      rdata_d = (r_ok && !r_bad_d) ? mem[r_idx_d[IDX_W-1:0]] : '0;
      rresp_d = !r_ok ? RESP_DECERR : (r_bad_d ? RESP_SLVERR : RESP_OKAY);
      rlast_d = (r_cnt_d == 8'd0);
    end
  end

  // State and control registers; RAM is deliberately left out of reset.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rdy_q     <= 1'b0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_below_q <= 1'b0;
      w_cnt_q   <= '0;
      w_bad_q   <= 1'b0;
      w_err_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_below_q <= 1'b0;
      r_cnt_q   <= '0;
      r_bad_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_below_q <= w_below_d;
      w_cnt_q   <= w_cnt_d;
      w_bad_q   <= w_bad_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_below_q <= r_below_d;
      r_cnt_q   <= r_cnt_d;
      r_bad_q   <= r_bad_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Byte-lane RAM write; a same-edge read sees the old word.
  always_ff @(posedge s00_axi_aclk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s00_axi.wstrb[b]) mem[w_idx_q[IDX_W-1:0]][8*b +: 8] <= s00_axi.wdata[8*b +: 8];
      end
    end
  end
endmodule
